codec_init_seq: RTL

//  Audio-codec (WM8731) power-up configuration sequencer; sits directly upstream of the i2c master.

---
 rtl/codec_init_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/codec_init_seq.sv
// codec_init_seq: power-up register-write sequencer for a WM8731 audio codec.
// Walks a fixed table of 16-bit {reg, data} words and hands each one to the
// downstream i2c master as a 24-bit {device address, word} transfer. A NACK or a
// missing completion is retried a bounded number of times before the sequence
// gives up and flags error. A clean run ends with the sticky done flag set.
module codec_init_seq #(
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter int         NUM_REGS    = 11,
    parameter int         SETTLE_CYC  = 50000,
    parameter int         GAP_CYC     = 500,
    parameter int         MAX_RETRY   = 3,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        i2c_idle,
    input  logic        i2c_done_tick,
    input  logic        i2c_fail,
    output logic [23:0] i2c_din,
    output logic        wr_i2c,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  reg_idx
);

    // One shared counter serves settle, gap and timeout, so it is sized for the longest.
    localparam int CNT_MAX_A = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYC) ? CNT_MAX_A : GAP_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
    localparam logic [3:0]         IDX_LAST     = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_GAP
    } state_t;

    state_t               state_reg,  state_next;
    logic [CNT_W-1:0]     cnt_reg,    cnt_next;
    logic [3:0]           idx_reg,    idx_next;
    logic [RETRY_W-1:0]   retry_reg,  retry_next;
    logic                 fail_reg,   fail_next;
    logic                 done_reg,   done_next;
    logic                 error_reg,  error_next;
    logic                 wr_reg,     wr_next;
    logic [23:0]          din_reg,    din_next;

    // Codec configuration words, {7-bit register, 9-bit data}.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = 16'h1E00;  // reset
            4'd1:    table_word = 16'h0017;  // left line in
            4'd2:    table_word = 16'h0217;  // right line in
            4'd3:    table_word = 16'h0479;  // left headphone out
            4'd4:    table_word = 16'h0679;  // right headphone out
            4'd5:    table_word = 16'h0812;  // analogue path
            4'd6:    table_word = 16'h0A00;  // digital path
            4'd7:    table_word = 16'h0C00;  // power down control
            4'd8:    table_word = 16'h0E02;  // digital audio interface format
            4'd9:    table_word = 16'h1000;  // sampling control
            4'd10:   table_word = 16'h1201;  // activate
            default: table_word = 16'h0000;
        endcase
    endfunction

    // Next-state and datapath decisions; i2c_din is loaded on every entry to ISSUE
    // so it is already stable in the cycle before the write strike.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        retry_next = retry_reg;
        fail_next  = fail_reg;
        done_next  = done_reg;
        error_next = error_reg;
        din_next   = din_reg;
        wr_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETTLE;
                    done_next  = 1'b0;
                    error_next = 1'b0;
                    idx_next   = 4'd0;
                    retry_next = '0;
                    cnt_next   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = S_ISSUE;
                    din_next   = {DEV_ADDR, table_word(idx_reg)};
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_ISSUE: begin
                if (i2c_idle) begin
                    wr_next    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completion in the same cycle as the timeout takes priority.
                if (i2c_done_tick) begin
                    fail_next  = i2c_fail;
                    state_next = S_CHECK;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    fail_next  = 1'b1;
                    state_next = S_CHECK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_CHECK: begin
                if (fail_reg) begin
                    if (retry_reg < RETRY_LIMIT) begin
                        retry_next = retry_reg + 1'b1;
                        cnt_next   = '0;
                        state_next = S_GAP;
                    end else begin
                        error_next = 1'b1;
                        state_next = S_IDLE;
                    end
                end else if (idx_reg == IDX_LAST) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    idx_next   = idx_reg + 4'd1;
                    retry_next = '0;
                    cnt_next   = '0;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = S_ISSUE;
                    din_next   = {DEV_ADDR, table_word(idx_reg)};
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= 4'd0;
            retry_reg <= '0;
            fail_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            wr_reg    <= 1'b0;
            din_reg   <= 24'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            retry_reg <= retry_next;
            fail_reg  <= fail_next;
            done_reg  <= done_next;
            error_reg <= error_next;
            wr_reg    <= wr_next;
            din_reg   <= din_next;
        end
    end

    assign i2c_din = din_reg;
    assign wr_i2c  = wr_reg;
    assign busy    = (state_reg != S_IDLE);
    assign done    = done_reg;
    assign error   = error_reg;
    assign reg_idx = idx_reg;

endmodule
